// File: rtl/exec_pkg.sv
// Shared definitions for the bf8b execute stage: opcodes, FSM states, flag bit positions.
package exec_pkg;

  localparam logic [3:0] OP_LOD  = 4'h1;
  localparam logic [3:0] OP_STR  = 4'h2;
  localparam logic [3:0] OP_ADD  = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LODI = 4'h5;
  localparam logic [3:0] OP_NAND = 4'h6;
  localparam logic [3:0] OP_SUB  = 4'h7;
  localparam logic [3:0] OP_AND  = 4'h8;
  localparam logic [3:0] OP_OR   = 4'h9;
  localparam logic [3:0] OP_XOR  = 4'hA;
  localparam logic [3:0] OP_SHL  = 4'hB;
  localparam logic [3:0] OP_SHR  = 4'hC;
  localparam logic [3:0] OP_ADC  = 4'hD;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_N = 2;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_WAIT = 2'd1,
    DONE     = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LOD) || (op == OP_STR);
  endfunction

endpackage

// File: rtl/exec_unit_if.sv
// Control-side request/result signals and the memory port of the execute stage.
interface exec_unit_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic              en;
  logic [3:0]        op;
  logic [DATA_W-1:0] reg0;
  logic [DATA_W-1:0] reg1;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] mem_data_in;
  logic              mem_ready;
  logic [DATA_W-1:0] val_out;
  logic              wb_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data_out;
  logic              mem_req;
  logic              mem_we;
  logic              ready;
  logic [2:0]        flags;
  logic              fault;

  // master is the environment (control plus memory); slave is the execute stage
  modport master (
    output en, op, reg0, reg1, imm, mem_data_in, mem_ready,
    input  val_out, wb_en, mem_addr, mem_data_out, mem_req, mem_we, ready, flags, fault
  );

  modport slave (
    input  en, op, reg0, reg1, imm, mem_data_in, mem_ready,
    output val_out, wb_en, mem_addr, mem_data_out, mem_req, mem_we, ready, flags, fault
  );
endinterface

// File: rtl/exec_alu.sv
// Combinational ALU: wrapping DATA_W-bit results with carry/borrow/shift-out and illegal-op detect.
module exec_alu
  import exec_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic [DATA_W-1:0] result,
  output logic              c,
  output logic              z,
  output logic              n,
  output logic              illegal
);

  logic [DATA_W:0] wide;

  always_comb begin
    wide    = '0;
    result  = '0;
    c       = 1'b0;
    illegal = 1'b0;
    case (op)
      OP_ADD, OP_ADDI: begin
        wide   = {1'b0, a} + {1'b0, b};
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      OP_ADC: begin
        wide   = {1'b0, a} + {1'b0, b} + (DATA_W+1)'(cin);
        result = wide[DATA_W-1:0];
        c      = wide[DATA_W];
      end
      OP_SUB: begin
        result = a - b;
        c      = (a < b);
      end
      OP_NAND: result = ~(a & b);
      OP_AND:  result = a & b;
      OP_OR:   result = a | b;
      OP_XOR:  result = a ^ b;
      OP_SHL: begin
        result = {a[DATA_W-2:0], 1'b0};
        c      = a[DATA_W-1];
      end
      OP_SHR: begin
        result = {1'b0, a[DATA_W-1:1]};
        c      = a[0];
      end
      OP_LODI: result = b;
      // memory ops are legal but produce no ALU result
      OP_LOD, OP_STR: result = '0;
      default: illegal = 1'b1;
    endcase
  end

  assign z = (result == '0);
  assign n = result[DATA_W-1];

endmodule

// File: rtl/exec_unit.sv
// Execute stage FSM: 1-cycle ALU/LODI, req/ready memory access with optional timeout,
// abort on en drop, illegal-op fault and persistent {N,Z,C} flags.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input logic        clk,
  input logic        rst,
  exec_unit_if.slave bus
);

  localparam int              CNT_W    = $clog2(MEM_TIMEOUT + 2);
  localparam bit              HAS_TO   = (MEM_TIMEOUT != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HAS_TO ? MEM_TIMEOUT - 1 : 0);

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt, cnt_n;
  logic [DATA_W-1:0] val_q, val_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] dout_q, dout_n;
  logic [2:0]        flags_q, flags_n;
  logic              req_q, req_n;
  logic              we_q, we_n;
  logic              ready_q, ready_n;
  logic              wb_q, wb_n;
  logic              fault_q, fault_n;

  logic [DATA_W-1:0] alu_b;
  logic [DATA_W-1:0] alu_result;
  logic              alu_c, alu_z, alu_n, alu_illegal;
  logic [DATA_W-1:0] addr_sum;

  assign alu_b    = (bus.op == OP_ADDI || bus.op == OP_LODI) ? bus.imm : bus.reg1;
  assign addr_sum = bus.reg1 + bus.imm;

  exec_alu #(.DATA_W(DATA_W)) u_alu (
    .op      (bus.op),
    .a       (bus.reg0),
    .b       (alu_b),
    .cin     (flags_q[FLAG_C]),
    .result  (alu_result),
    .c       (alu_c),
    .z       (alu_z),
    .n       (alu_n),
    .illegal (alu_illegal)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      val_q   <= '0;
      addr_q  <= '0;
      dout_q  <= '0;
      flags_q <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      wb_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      val_q   <= val_n;
      addr_q  <= addr_n;
      dout_q  <= dout_n;
      flags_q <= flags_n;
      req_q   <= req_n;
      we_q    <= we_n;
      ready_q <= ready_n;
      wb_q    <= wb_n;
      fault_q <= fault_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    val_n   = val_q;
    addr_n  = addr_q;
    dout_n  = dout_q;
    flags_n = flags_q;
    req_n   = req_q;
    we_n    = we_q;
    ready_n = ready_q;
    wb_n    = wb_q;
    fault_n = fault_q;
    case (state)
      IDLE: begin
        ready_n = 1'b0;
        wb_n    = 1'b0;
        fault_n = 1'b0;
        if (bus.en) begin
          if (is_mem_op(bus.op)) begin
            addr_n  = ADDR_W'(addr_sum);
            dout_n  = bus.reg0;
            we_n    = (bus.op == OP_STR);
            req_n   = 1'b1;
            cnt_n   = '0;
            state_n = MEM_WAIT;
          end else if (alu_illegal) begin
            ready_n = 1'b1;
            fault_n = 1'b1;
            state_n = DONE;
          end else begin
            val_n   = alu_result;
            wb_n    = 1'b1;
            ready_n = 1'b1;
            state_n = DONE;
            if (bus.op != OP_LODI) begin
              flags_n[FLAG_N] = alu_n;
              flags_n[FLAG_Z] = alu_z;
              flags_n[FLAG_C] = alu_c;
            end
          end
        end
      end
      MEM_WAIT: begin
        // an en drop wins over a same-cycle mem_ready
        if (!bus.en) begin
          req_n   = 1'b0;
          we_n    = 1'b0;
          state_n = IDLE;
        end else if (bus.mem_ready) begin
          req_n   = 1'b0;
          we_n    = 1'b0;
          ready_n = 1'b1;
          state_n = DONE;
          if (we_q) begin
            wb_n = 1'b0;
          end else begin
            val_n = bus.mem_data_in;
            wb_n  = 1'b1;
          end
        end else if (HAS_TO && cnt == CNT_LAST) begin
          req_n   = 1'b0;
          we_n    = 1'b0;
          ready_n = 1'b1;
          fault_n = 1'b1;
          wb_n    = 1'b0;
          state_n = DONE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      DONE: begin
        if (!bus.en) begin
          ready_n = 1'b0;
          wb_n    = 1'b0;
          fault_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.val_out      = val_q;
  assign bus.wb_en        = wb_q;
  assign bus.mem_addr     = addr_q;
  assign bus.mem_data_out = dout_q;
  assign bus.mem_req      = req_q;
  assign bus.mem_we       = we_q;
  assign bus.ready        = ready_q;
  assign bus.flags        = flags_q;
  assign bus.fault        = fault_q;

endmodule

// File: tb/tb_exec_unit.sv
// Self-checking bench for exec_unit: transaction-level reference model plus per-cycle compare.
module tb_exec_unit;
  import exec_pkg::*;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exec_unit_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  exec_unit #(.DATA_W(DW), .ADDR_W(AW), .MEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;
  int req_total = 0;

  // expected architectural outputs, maintained by the transaction model
  logic [7:0] exp_val, exp_addr, exp_dout;
  logic [2:0] exp_flags;
  logic       exp_wb, exp_req, exp_we, exp_ready, exp_fault;

  logic done_ready, done_fault, done_wb;

  // literal expectations queued by the stimulus, drained by the compare process
  string       lit_name [64];
  logic [31:0] lit_act  [64];
  logic [31:0] lit_exp  [64];
  int          lit_wr = 0;
  int          lit_rd = 0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (bus.mem_req === 1'b1) req_total++;
    if (chk_on) begin
      checkOutput("val_out",      32'(bus.val_out),      32'(exp_val));
      checkOutput("wb_en",        32'(bus.wb_en),        32'(exp_wb));
      checkOutput("mem_addr",     32'(bus.mem_addr),     32'(exp_addr));
      checkOutput("mem_data_out", 32'(bus.mem_data_out), 32'(exp_dout));
      checkOutput("mem_req",      32'(bus.mem_req),      32'(exp_req));
      checkOutput("mem_we",       32'(bus.mem_we),       32'(exp_we));
      checkOutput("ready",        32'(bus.ready),        32'(exp_ready));
      checkOutput("flags",        32'(bus.flags),        32'(exp_flags));
      checkOutput("fault",        32'(bus.fault),        32'(exp_fault));
    end
    while (lit_rd < lit_wr) begin
      checkOutput(lit_name[lit_rd], lit_act[lit_rd], lit_exp[lit_rd]);
      lit_rd++;
    end
  end

  task automatic expectLiteral(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (lit_wr < 64) begin
      lit_name[lit_wr] = name;
      lit_act[lit_wr]  = act;
      lit_exp[lit_wr]  = exp;
      lit_wr++;
    end
  endtask

  function automatic void alu_ref(input logic [3:0] op, input int a, input int b, input int im,
                                  input int cin, output int res, output int c,
                                  output bit upd, output bit ill);
    res = 0; c = 0; upd = 1'b1; ill = 1'b0;
    case (op)
      OP_ADD:  begin res = a + b;       c = (res > 255) ? 1 : 0; end
      OP_ADDI: begin res = a + im;      c = (res > 255) ? 1 : 0; end
      OP_ADC:  begin res = a + b + cin; c = (res > 255) ? 1 : 0; end
      OP_SUB:  begin res = a - b;       c = (a < b) ? 1 : 0; end
      OP_NAND: res = ~(a & b);
      OP_AND:  res = a & b;
      OP_OR:   res = a | b;
      OP_XOR:  res = a ^ b;
      OP_SHL:  begin res = a * 2; c = (a >= 128) ? 1 : 0; end
      OP_SHR:  begin res = a / 2; c = a % 2; end
      OP_LODI: begin res = im; upd = 1'b0; end
      default: begin ill = 1'b1; upd = 1'b0; end
    endcase
    res = res & 255;
  endfunction

  // one full transaction: request, completion/abort/timeout, optional hold, en release
  task automatic applyStimulus(input logic [3:0] op, input logic [7:0] r0, input logic [7:0] r1,
                               input logic [7:0] im, input int resp_at, input logic [7:0] rdata,
                               input int abort_at, input int hold);
    int res, c;
    bit upd, ill, aborted;
    aborted = 1'b0;
    bus.op = op; bus.reg0 = r0; bus.reg1 = r1; bus.imm = im; bus.en = 1'b1;
    bus.mem_ready = 1'($urandom); bus.mem_data_in = 8'($urandom);
    @(posedge clk); #2;
    bus.reg0 = 8'($urandom); bus.reg1 = 8'($urandom); bus.imm = 8'($urandom);
    if (op == OP_LOD || op == OP_STR) begin
      exp_addr = 8'((int'(r1) + int'(im)) % 256);
      exp_dout = r0; exp_we = (op == OP_STR); exp_req = 1'b1;
      exp_ready = 1'b0; exp_wb = 1'b0; exp_fault = 1'b0;
      for (int k = 1; k <= TO; k++) begin
        bus.mem_ready   = (k == resp_at);
        bus.mem_data_in = (k == resp_at) ? rdata : 8'($urandom);
        if (k == abort_at) bus.en = 1'b0;
        @(posedge clk); #2;
        bus.mem_ready = 1'b0;
        if (k == abort_at) begin
          exp_req = 1'b0; exp_we = 1'b0; aborted = 1'b1;
          break;
        end else if (k == resp_at) begin
          exp_req = 1'b0; exp_we = 1'b0; exp_ready = 1'b1;
          if (op == OP_LOD) begin exp_val = rdata; exp_wb = 1'b1; end
          break;
        end else if (k == TO) begin
          exp_req = 1'b0; exp_we = 1'b0; exp_ready = 1'b1; exp_fault = 1'b1; exp_wb = 1'b0;
        end
      end
    end else begin
      alu_ref(op, int'(r0), int'(r1), int'(im), int'(exp_flags[FLAG_C]), res, c, upd, ill);
      if (ill) begin
        exp_ready = 1'b1; exp_fault = 1'b1; exp_wb = 1'b0;
      end else begin
        exp_val = 8'(res); exp_wb = 1'b1; exp_ready = 1'b1; exp_fault = 1'b0;
        if (upd) exp_flags = {(res >= 128), (res == 0), (c != 0)};
      end
    end
    done_ready = bus.ready; done_fault = bus.fault; done_wb = bus.wb_en;
    if (!aborted) begin
      repeat (hold) begin
        bus.reg0 = 8'($urandom); bus.mem_ready = 1'($urandom);
        @(posedge clk); #2;
      end
    end
    bus.en = 1'b0; bus.mem_ready = 1'($urandom);
    @(posedge clk); #2;
    exp_ready = 1'b0; exp_wb = 1'b0; exp_fault = 1'b0;
  endtask

  task automatic resetMidLoad(input logic [7:0] r1, input logic [7:0] im);
    bus.op = OP_LOD; bus.reg0 = 8'h77; bus.reg1 = r1; bus.imm = im;
    bus.en = 1'b1; bus.mem_ready = 1'b0;
    @(posedge clk); #2;
    exp_addr = 8'((int'(r1) + int'(im)) % 256); exp_dout = 8'h77;
    exp_we = 1'b0; exp_req = 1'b1;
    @(posedge clk); #2;
    rst = 1'b1; bus.en = 1'b0;
    @(posedge clk); #2;
    exp_val = '0; exp_addr = '0; exp_dout = '0; exp_flags = '0;
    exp_req = 1'b0; exp_we = 1'b0; exp_ready = 1'b0; exp_wb = 1'b0; exp_fault = 1'b0;
    rst = 1'b0;
    @(posedge clk); #2;
  endtask

  initial begin
    int start, op, sel, resp, abrt;
    rst = 1'b1;
    bus.en = 1'b0; bus.op = '0; bus.reg0 = '0; bus.reg1 = '0; bus.imm = '0;
    bus.mem_ready = 1'b0; bus.mem_data_in = '0;
    exp_val = '0; exp_addr = '0; exp_dout = '0; exp_flags = '0;
    exp_wb = 1'b0; exp_req = 1'b0; exp_we = 1'b0; exp_ready = 1'b0; exp_fault = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk_on = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    applyStimulus(OP_ADD, 8'hF0, 8'h20, 8'h00, 0, 8'h00, 0, 1);
    expectLiteral("add_val", 32'(bus.val_out), 32'h10);
    expectLiteral("add_flags", 32'(bus.flags), 32'b001);
    expectLiteral("add_ready", 32'(done_ready), 32'd1);
    expectLiteral("add_wb", 32'(done_wb), 32'd1);

    applyStimulus(OP_ADC, 8'h01, 8'h01, 8'h00, 0, 8'h00, 0, 0);
    expectLiteral("adc_val", 32'(bus.val_out), 32'h03);

    applyStimulus(OP_SUB, 8'h05, 8'h05, 8'h00, 0, 8'h00, 0, 0);
    expectLiteral("sub_eq_val", 32'(bus.val_out), 32'h00);
    expectLiteral("sub_eq_flags", 32'(bus.flags), 32'b010);

    applyStimulus(OP_SUB, 8'h03, 8'h05, 8'h00, 0, 8'h00, 0, 0);
    expectLiteral("sub_neg_val", 32'(bus.val_out), 32'hFE);
    expectLiteral("sub_neg_flags", 32'(bus.flags), 32'b101);

    start = req_total;
    applyStimulus(OP_LOD, 8'h00, 8'h10, 8'h05, 3, 8'hA5, 0, 1);
    expectLiteral("lod_addr", 32'(bus.mem_addr), 32'h15);
    expectLiteral("lod_req_cycles", 32'(req_total - start), 32'd3);
    expectLiteral("lod_val", 32'(bus.val_out), 32'hA5);
    expectLiteral("lod_wb", 32'(done_wb), 32'd1);
    expectLiteral("lod_flags", 32'(bus.flags), 32'b101);

    start = req_total;
    applyStimulus(OP_STR, 8'h3C, 8'hFF, 8'h02, 99, 8'h00, 0, 0);
    expectLiteral("str_addr", 32'(bus.mem_addr), 32'h01);
    expectLiteral("str_dout", 32'(bus.mem_data_out), 32'h3C);
    expectLiteral("str_req_cycles", 32'(req_total - start), 32'd15);
    expectLiteral("str_fault", 32'(done_fault), 32'd1);
    expectLiteral("str_wb", 32'(done_wb), 32'd0);

    applyStimulus(4'hF, 8'h12, 8'h34, 8'h56, 0, 8'h00, 0, 0);
    expectLiteral("ill_ready", 32'(done_ready), 32'd1);
    expectLiteral("ill_fault", 32'(done_fault), 32'd1);
    expectLiteral("ill_val", 32'(bus.val_out), 32'hA5);
    expectLiteral("ill_flags", 32'(bus.flags), 32'b101);
    expectLiteral("ill_release_fault", 32'(bus.fault), 32'd0);

    start = req_total;
    applyStimulus(OP_LOD, 8'h00, 8'h20, 8'h01, 2, 8'h5A, 2, 0);
    expectLiteral("abort_ready", 32'(done_ready), 32'd0);
    expectLiteral("abort_val", 32'(bus.val_out), 32'hA5);
    expectLiteral("abort_req_cycles", 32'(req_total - start), 32'd2);

    resetMidLoad(8'h40, 8'h04);
    expectLiteral("rst_val", 32'(bus.val_out), 32'h00);
    expectLiteral("rst_flags", 32'(bus.flags), 32'b000);
    applyStimulus(OP_ADD, 8'h01, 8'h02, 8'h00, 0, 8'h00, 0, 0);
    expectLiteral("post_rst_add", 32'(bus.val_out), 32'h03);

    for (int i = 0; i < 150; i++) begin
      op = $urandom_range(0, 15);
      sel = $urandom_range(0, 9);
      resp = 0; abrt = 0;
      if (sel < 7) begin
        resp = $urandom_range(1, 5);
      end else if (sel == 7) begin
        resp = 99;
      end else begin
        resp = $urandom_range(1, 5);
        abrt = $urandom_range(1, 4);
      end
      applyStimulus(4'(op), 8'($urandom), 8'($urandom), 8'($urandom), resp, 8'($urandom),
                    abrt, $urandom_range(0, 2));
    end

    repeat (3) @(posedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
